// File: rtl/heavyhash_pkg.sv
// Shared types and helpers for the heavyhash XOR/pack stage.
package heavyhash_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HLOAD   = 2'd1,
    COLLECT = 2'd2,
    EMIT    = 2'd3
  } state_e;

  localparam int ROWS_DEF   = 64;
  localparam int PROD_W_DEF = 16;
  localparam int SHIFT_DEF  = 10;
  localparam int HASH_W_DEF = 256;

  // Keep bits [shift+3:shift] of a product; everything above and below is dropped.
  function automatic logic [3:0] nib_of(input logic [31:0] product, input int shift);
    logic [31:0] s;
    s = product >> shift;
    return s[3:0];
  endfunction

endpackage

// File: rtl/heavyhash_xor_packer_nibble_packer.sv
// Nibble shift register: nibbles enter at the top slot and walk down, so after
// ROWS captures the first nibble sits in slot 0. Slot 2k is the upper nibble of byte k.
module nibble_packer
  import heavyhash_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int HASH_W = HASH_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en,
  input  logic              clr,
  input  logic [3:0]        nib_in,
  output logic [HASH_W-1:0] packed_o
);

  logic [ROWS-1:0][3:0] sr_q, sr_d;

  // Next slot contents: clear wins over capture.
  always_comb begin
    sr_d = sr_q;
    if (clr)         sr_d = '0;
    else if (cap_en) sr_d = {nib_in, sr_q[ROWS-1:1]};
  end

  // Slot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  for (genvar k = 0; k < ROWS/2; k++) begin : g_byte
    assign packed_o[8*k +: 8] = {sr_q[2*k], sr_q[2*k+1]};
  end

endmodule

// File: rtl/heavyhash_xor_packer.sv
// Drains ROWS dot products for one hash, packs their nibbles and XORs with the
// original hash. Optional perf counters: define HH_PERF_CNT_EN.
module heavyhash_xor_packer
  import heavyhash_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int PROD_W = PROD_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int HASH_W = HASH_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hashout_empty,
  input  logic [PROD_W-1:0] hashout_dout,
  output logic              hashout_re,
  input  logic              horig_empty,
  input  logic [HASH_W-1:0] horig_dout,
  output logic              horig_re,
  output logic [HASH_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
`ifdef HH_PERF_CNT_EN
  input  logic              clear_cnt,
  output logic [31:0]       res_count,
  output logic [31:0]       stall_count,
`endif
  output logic              busy
);

  localparam int CW = $clog2(ROWS + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;   // nibbles captured
  logic [CW-1:0]     iss_q, iss_d;   // reads issued; caps reads at ROWS per hash
  logic              rd_q, rd_d;     // hashout_dout valid this cycle
  logic [HASH_W-1:0] hash_q, hash_d;
  logic [HASH_W-1:0] packed_w;
  logic              hre, hrg_re, cap_en, pk_clr, hs;
  logic [3:0]        nib;

  assign nib       = nib_of(32'(hashout_dout), SHIFT);
  assign res_valid = (state_q == EMIT);
  assign hs        = res_valid && res_ready;
  assign busy      = (state_q != IDLE);
  assign res_data  = res_valid ? (packed_w ^ hash_q) : '0;
  assign hashout_re = hre;
  assign horig_re   = hrg_re;

  // Next-state, FIFO reads and capture control.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    iss_d   = iss_q;
    hash_d  = hash_q;
    rd_d    = 1'b0;
    hre     = 1'b0;
    hrg_re  = 1'b0;
    cap_en  = 1'b0;
    pk_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!horig_empty) begin
          hrg_re  = 1'b1;
          state_d = HLOAD;
        end
      end
      HLOAD: begin
        hash_d  = horig_dout;
        state_d = COLLECT;
      end
      COLLECT: begin
        hre  = !hashout_empty && (iss_q != CW'(ROWS));
        rd_d = hre;
        if (hre) iss_d = iss_q + 1'b1;
        if (rd_q) begin
          cap_en = 1'b1;
          idx_d  = idx_q + 1'b1;
          if (idx_q == CW'(ROWS - 1)) state_d = EMIT;
        end
      end
      EMIT: begin
        if (res_ready) begin
          state_d = IDLE;
          idx_d   = '0;
          iss_d   = '0;
          hash_d  = '0;
          pk_clr  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and hash registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      iss_q   <= '0;
      rd_q    <= 1'b0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      iss_q   <= iss_d;
      rd_q    <= rd_d;
      hash_q  <= hash_d;
    end
  end

  nibble_packer #(.ROWS(ROWS), .HASH_W(HASH_W)) u_pack (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_en   (cap_en),
    .clr      (pk_clr),
    .nib_in   (nib),
    .packed_o (packed_w)
  );

`ifdef HH_PERF_CNT_EN
  logic [31:0] res_count_q, res_count_d, stall_count_q, stall_count_d;

  // Handshake and stall counters; wrap naturally, clear has priority.
  always_comb begin
    res_count_d   = res_count_q;
    stall_count_d = stall_count_q;
    if (clear_cnt) begin
      res_count_d   = '0;
      stall_count_d = '0;
    end else begin
      if (hs) res_count_d = res_count_q + 32'd1;
      if ((state_q == COLLECT && hashout_empty) || (state_q == EMIT && !res_ready))
        stall_count_d = stall_count_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      res_count_q   <= res_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign res_count   = res_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_heavyhash_xor_packer.sv
// Scoreboard bench: FIFO models feed the DUT, expected results queued on load.
module tb_heavyhash_xor_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         hashout_empty, hashout_re, horig_empty, horig_re;
  logic         res_valid, res_ready, busy;
  logic [15:0]  hashout_dout = '0;
  logic [255:0] horig_dout = '0;
  logic [255:0] res_data;
`ifdef HH_PERF_CNT_EN
  logic         clear_cnt;
  logic [31:0]  res_count, stall_count;
`endif

  heavyhash_xor_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hashout_empty (hashout_empty),
    .hashout_dout  (hashout_dout),
    .hashout_re    (hashout_re),
    .horig_empty   (horig_empty),
    .horig_dout    (horig_dout),
    .horig_re      (horig_re),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
`ifdef HH_PERF_CNT_EN
    .clear_cnt     (clear_cnt),
    .res_count     (res_count),
    .stall_count   (stall_count),
`endif
    .busy          (busy)
  );

  // FIFO storage: writers are the stimulus process, readers the model below.
  logic [15:0]  pmem [0:1023];
  logic [255:0] hmem [0:15];
  int pw = 0, pr = 0, hw = 0, hr = 0, cyc = 0;
  logic gap_en = 1'b0, gap_tgl = 1'b0;

  assign hashout_empty = (pr == pw) || (gap_en && gap_tgl);
  assign horig_empty   = (hr == hw);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    gap_tgl <= ~gap_tgl;
    if (hashout_re) begin
      hashout_dout <= pmem[pr];
      pr <= pr + 1;
    end
    if (horig_re) begin
      horig_dout <= hmem[hr];
      hr <= hr + 1;
    end
  end

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  logic [255:0] exp_q[$];
  int   res_cnt = 0, rd_cnt = 0, last_rd = 0;
  logic prev_vld = 1'b0, prev_acc = 1'b0;
  logic [255:0] last_data = '0;

  // Reference: nibble i of 64 goes to byte i/2, upper half when i is even.
  function automatic logic [255:0] exp_of(input int base, input logic [255:0] h);
    logic [255:0] r;
    logic [15:0]  p;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      p = pmem[base + i];
      r[8*(i/2) + ((i % 2) ? 0 : 4) +: 4] = p[13:10];
    end
    return r ^ h;
  endfunction

  task automatic load(input int kind, input logic [255:0] h, input bit expect_it);
    int base;
    base = pw;
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0:       pmem[pw] = 16'h0000;
        1:       pmem[pw] = 16'(i << 10);
        2:       pmem[pw] = 16'hFFFF;
        default: pmem[pw] = 16'($urandom);
      endcase
      pw++;
    end
    hmem[hw] = h;
    hw++;
    if (expect_it) exp_q.push_back(exp_of(base, h));
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] h;
    for (int j = 0; j < 8; j++) h[32*j +: 32] = $urandom;
    return h;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 1'b0;
        prev_acc = 1'b0;
      end else begin
        if (hashout_re) begin
          rd_cnt++;
          last_rd = cyc;
        end
        if (res_valid) begin
          chk("no_read_in_emit", {254'b0, horig_re, hashout_re}, '0);
          if (!prev_vld || prev_acc) chk("latency", 256'(cyc - last_rd), 256'd2);
          if (exp_q.size() == 0) chk("unexpected_result", 256'(exp_q.size()), 256'd1);
          else begin
            chk("res_data", res_data, exp_q[0]);
            if (res_ready) begin
              last_data = res_data;
              void'(exp_q.pop_front());
              res_cnt++;
            end
          end
        end
        prev_vld = res_valid;
        prev_acc = res_valid && res_ready;
      end
    end
  endtask

  task automatic wait_res(input int n);
    int i;
    i = 0;
    while (res_cnt < n && i < 4000) begin
      @(negedge clk);
      i++;
    end
    chk("res_cnt", 256'(res_cnt), 256'(n));
  endtask

  initial begin
    int r0, i;
    res_ready = 1'b1;
`ifdef HH_PERF_CNT_EN
    clear_cnt = 1'b0;
`endif
    fork
      monitor();
    join_none

    // Reset values, then idle with empty hash FIFO.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {252'b0, busy, res_valid, hashout_re, horig_re}, '0);
    chk("rst_data", res_data, '0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_no_hash", {254'b0, busy, horig_re}, '0);

    // All-zero products, hash 0xA5.
    load(0, {32{8'hA5}}, 1'b1);
    wait_res(1);

    // Product i = i<<10, zero hash.
    load(1, '0, 1'b1);
    wait_res(2);
    chk("byte0", 256'(last_data[7:0]), 256'h01);
    chk("byte7", 256'(last_data[63:56]), 256'hEF);
    chk("byte8", 256'(last_data[71:64]), 256'h01);

    // All 0xFFFF products against all-ones hash.
    load(2, '1, 1'b1);
    wait_res(3);
    chk("ones_zero", last_data, '0);

    // Gappy FIFO and backpressure.
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    gap_en = 1'b1;
    r0 = rd_cnt;
    load(3, rnd256(), 1'b1);
    i = 0;
    while (!res_valid && i < 4000) begin
      @(negedge clk);
      i++;
    end
    chk("stall_valid", {255'b0, res_valid}, 256'd1);
    repeat (5) @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_res(4);
    gap_en = 1'b0;
    chk("stall_reads", 256'(rd_cnt - r0), 256'd64);

    // Two hashes plus two extra products.
    r0 = rd_cnt;
    load(3, rnd256(), 1'b1);
    load(3, rnd256(), 1'b1);
    pmem[pw] = 16'h1234; pw++;
    pmem[pw] = 16'h5678; pw++;
    wait_res(6);
    repeat (10) @(posedge clk);
    #1;
    chk("two_hash_reads", 256'(rd_cnt - r0), 256'd128);
    chk("leftover", 256'(pw - pr), 256'd2);

    // Reset after 30 products (2 leftovers + 28 new), then a clean hash.
    r0 = rd_cnt;
    hmem[hw] = rnd256(); hw++;
    for (int k = 0; k < 28; k++) begin
      pmem[pw] = 16'($urandom);
      pw++;
    end
    i = 0;
    while ((rd_cnt - r0) < 30 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("partial_reads", 256'(rd_cnt - r0), 256'd30);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_busy", {255'b0, busy}, 256'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {252'b0, busy, res_valid, hashout_re, horig_re}, '0);
    chk("async_rst_data", res_data, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    load(3, rnd256(), 1'b1);
    wait_res(7);
`ifdef HH_PERF_CNT_EN
    chk("res_count", 256'(res_count), 256'd1);
`endif
    chk("exp_q_drained", 256'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
